// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared opcodes, control state encoding and datapath select encodings
package mips_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RTWB   = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;
  // Unsupported opcodes fall back to FETCH, which doubles as the illegal marker
  function automatic state_t decode_target(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: return S_MEMADR;
      OP_RTYPE:     return S_EXEC;
      OP_BEQ:       return S_BRANCH;
      OP_J:         return S_JUMP;
      OP_ADDI:      return S_ADDIEX;
      default:      return S_FETCH;
    endcase
  endfunction
endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM sequencing the multicycle MIPS datapath
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       illegal_op,
  output logic [3:0] state
);
  state_t state_q, state_d;
  assign state = state_q;
  // state register; reset drops straight to IDLE so every output decodes to 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  // next state; memory states hold until mem_ready completes the access
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = decode_target(opcode);
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RTWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end
  // output decode; only the fetch load strobes and illegal_op look at inputs
  always_comb begin
    pc_write = 1'b0; pc_write_cond = 1'b0; i_or_d = 1'b0; mem_read = 1'b0;
    mem_write = 1'b0; mem_to_reg = 1'b0; ir_write = 1'b0; pc_source = PCSRC_ALU;
    alu_op = ALU_ADD; alu_src_a = 1'b0; alu_src_b = SRCB_B; reg_write = 1'b0;
    reg_dst = 1'b0; illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1; alu_src_b = SRCB_FOUR;
        ir_write = mem_ready; pc_write = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        illegal_op = (decode_target(opcode) == S_FETCH);
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1; alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1; i_or_d = 1'b1;
      end
      S_MEMWB: begin
        reg_write = 1'b1; mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1; i_or_d = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1; alu_op = ALU_FUNCT;
      end
      S_RTWB: begin
        reg_write = 1'b1; reg_dst = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1; alu_op = ALU_SUB; pc_write_cond = 1'b1; pc_source = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write = 1'b1; pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: reg_write = 1'b1;
      default: ;
    endcase
  end
endmodule
